// File: rtl/cache_coherence_agent.sv
// MSI snooping-bus agent: local access FSM plus per-line tag/state array with
// a snoop port that is serviced every cycle regardless of FSM state.
module cache_coherence_agent #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_done,
  output logic              read_miss,
  output logic              write_miss,
  output logic              invalidate,
  output logic [ADDR_W-1:0] BICO,
  input  logic              grant,
  input  logic              cpu_search,
  input  logic              cpu_datasel,
  input  logic [ADDR_W-1:0] BOCI,
  output logic              cpu_search_found,
  output logic [1:0]        block_state,
  input  logic              invalidate_from_other_cpu,
  output logic              cpu_invalidate_dmem
);

  localparam int IDX = $clog2(LINES);
  localparam int TAG = ADDR_W - IDX;

  typedef enum logic [1:0] {L_I = 2'b00, L_S = 2'b01, L_M = 2'b10} line_st_e;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REQ, S_DONE} fsm_e;
  typedef enum logic [1:0] {K_RD, K_WR, K_UP} kind_e;

  line_st_e        r_state [LINES];
  logic [TAG-1:0]  r_tag   [LINES];

  fsm_e            r_fsm, w_fsm_nxt;
  kind_e           r_kind, w_kind_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic            r_we;
  logic            r_found;
  line_st_e        r_bstate;

  logic [IDX-1:0]  w_req_idx, w_snp_idx;
  logic [TAG-1:0]  w_req_tag, w_snp_tag;
  logic            w_req_match, w_lk_hit, w_victim_m;
  logic            w_snp_match, w_snp_hit, w_snp_inv, w_snp_dn;
  logic            w_grant_upd, w_wb_evict;

  assign w_req_idx   = r_addr[IDX-1:0];
  assign w_req_tag   = r_addr[ADDR_W-1:IDX];
  assign w_req_match = (r_tag[w_req_idx] == w_req_tag);
  assign w_lk_hit    = w_req_match &&
                       (r_state[w_req_idx] == L_S || r_state[w_req_idx] == L_M);
  assign w_victim_m  = !w_req_match && (r_state[w_req_idx] == L_M);

  assign w_snp_idx   = BOCI[IDX-1:0];
  assign w_snp_tag   = BOCI[ADDR_W-1:IDX];
  assign w_snp_match = (r_tag[w_snp_idx] == w_snp_tag);
  assign w_snp_hit   = w_snp_match &&
                       (r_state[w_snp_idx] == L_S || r_state[w_snp_idx] == L_M);
  assign w_snp_inv   = invalidate_from_other_cpu && w_snp_match;
  assign w_snp_dn    = cpu_search && cpu_datasel && w_snp_match &&
                       (r_state[w_snp_idx] == L_M);

  assign w_grant_upd = (r_fsm == S_REQ) && grant;
  assign w_wb_evict  = (r_fsm == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm  <= S_IDLE;
      r_kind <= K_RD;
      r_addr <= '0;
      r_we   <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_kind <= w_kind_nxt;
      if (r_fsm == S_IDLE && req_valid) begin
        r_addr <= req_addr;
        r_we   <= req_we;
      end
    end
  end

  always_comb begin
    w_fsm_nxt           = r_fsm;
    w_kind_nxt          = r_kind;
    req_done            = 1'b0;
    read_miss           = 1'b0;
    write_miss          = 1'b0;
    invalidate          = 1'b0;
    BICO                = '0;
    cpu_invalidate_dmem = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (req_valid) w_fsm_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_lk_hit && (!r_we || r_state[w_req_idx] == L_M)) begin
          w_fsm_nxt = S_DONE;
        end else begin
          if (w_lk_hit)  w_kind_nxt = K_UP;
          else if (r_we) w_kind_nxt = K_WR;
          else           w_kind_nxt = K_RD;
          w_fsm_nxt = w_victim_m ? S_WB : S_REQ;
        end
      end
      S_WB: begin
        cpu_invalidate_dmem = 1'b1;
        BICO                = {r_tag[w_req_idx], w_req_idx};
        w_fsm_nxt           = S_REQ;
      end
      S_REQ: begin
        BICO       = r_addr;
        read_miss  = (r_kind == K_RD);
        write_miss = (r_kind == K_WR);
        invalidate = (r_kind == K_UP);
        if (grant) begin
          w_fsm_nxt = S_DONE;
        end else if (r_kind == K_UP && invalidate_from_other_cpu && BOCI == r_addr) begin
          // our shared copy was killed before the upgrade won: must refetch
          w_kind_nxt = K_WR;
        end
      end
      S_DONE: begin
        req_done  = 1'b1;
        w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // later assignments win: grant > snoop invalidate > datasel downgrade > eviction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '{default: L_I};
      r_tag   <= '{default: '0};
    end else begin
      if (w_wb_evict) r_state[w_req_idx] <= L_I;
      if (w_snp_dn)   r_state[w_snp_idx] <= L_S;
      if (w_snp_inv)  r_state[w_snp_idx] <= L_I;
      if (w_grant_upd) begin
        r_state[w_req_idx] <= (r_kind == K_RD) ? L_S : L_M;
        r_tag[w_req_idx]   <= w_req_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_found  <= 1'b0;
      r_bstate <= L_I;
    end else begin
      r_found  <= cpu_search && w_snp_hit;
      r_bstate <= (cpu_search && w_snp_hit) ? r_state[w_snp_idx] : L_I;
    end
  end

  assign cpu_search_found = r_found;
  assign block_state      = (r_fsm == S_REQ) ? (w_lk_hit ? r_state[w_req_idx] : L_I)
                                             : r_bstate;

endmodule

// File: tb/tb_cache_coherence_agent.sv
// Self-checking bench for cache_coherence_agent: directed table, hand-written
// corner sequences, then random traffic against a per-line MSI model.
module tb_cache_coherence_agent;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [10:0] req_addr;
  logic        req_done, read_miss, write_miss, invalidate;
  logic [10:0] BICO;
  logic        grant, cpu_search, cpu_datasel;
  logic [10:0] BOCI;
  logic        cpu_search_found;
  logic [1:0]  block_state;
  logic        invalidate_from_other_cpu, cpu_invalidate_dmem;

  cache_coherence_agent #(.LINES(8), .ADDR_W(11)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .req_valid                 (req_valid),
    .req_we                    (req_we),
    .req_addr                  (req_addr),
    .req_done                  (req_done),
    .read_miss                 (read_miss),
    .write_miss                (write_miss),
    .invalidate                (invalidate),
    .BICO                      (BICO),
    .grant                     (grant),
    .cpu_search                (cpu_search),
    .cpu_datasel               (cpu_datasel),
    .BOCI                      (BOCI),
    .cpu_search_found          (cpu_search_found),
    .block_state               (block_state),
    .invalidate_from_other_cpu (invalidate_from_other_cpu),
    .cpu_invalidate_dmem       (cpu_invalidate_dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: tag and MSI state (0 I, 1 S, 2 M) per line
  int m_tag [8];
  int m_st  [8];

  typedef struct {
    bit          snp;
    logic [10:0] addr;
    bit          we;
    bit          srch;
    bit          dsel;
    bit          inv;
    int          kind;   // 0 hit, 1 read_miss, 2 write_miss, 3 invalidate
    bit          wb;
    int          wba;
    int          found;
    int          bs;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bus_flags();
    return int'({read_miss, write_miss, invalidate});
  endfunction

  function automatic int kind_flags(input int k);
    if (k == 1) return 4;
    if (k == 2) return 2;
    if (k == 3) return 1;
    return 0;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_done"},  int'(req_done), 0);
    chk({nm, "_bus"},   bus_flags(), 0);
    chk({nm, "_bico"},  int'(BICO), 0);
    chk({nm, "_dmem"},  int'(cpu_invalidate_dmem), 0);
    chk({nm, "_found"}, int'(cpu_search_found), 0);
    chk({nm, "_bstate"}, int'(block_state), 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_tag[i] = 0;
      m_st[i]  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; grant = 1'b0;
    cpu_search = 1'b0; cpu_datasel = 1'b0; BOCI = '0;
    invalidate_from_other_cpu = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_clear();
  endtask

  // one local access from IDLE with the expected bus behaviour spelled out
  task automatic access_exp(input logic [10:0] a, input bit we, input int gd,
                            input int kind, input bit wb, input int wba, input int bs);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    tick();
    chk("lookup_nodone", int'(req_done), 0);
    chk("lookup_nobus", bus_flags(), 0);
    tick();
    if (kind == 0) begin
      chk("hit_done", int'(req_done), 1);
      chk("hit_nobus", bus_flags(), 0);
    end else begin
      if (wb) begin
        chk("wb_dmem", int'(cpu_invalidate_dmem), 1);
        chk("wb_bico", int'(BICO), wba);
        chk("wb_nobus", bus_flags(), 0);
        tick();
      end else begin
        chk("no_wb", int'(cpu_invalidate_dmem), 0);
      end
      for (int d = 0; d <= gd; d++) begin
        chk("req_kind", bus_flags(), kind_flags(kind));
        chk("req_bico", int'(BICO), int'(a));
        chk("req_bstate", int'(block_state), bs);
        chk("req_nodone", int'(req_done), 0);
        if (d == gd) grant = 1'b1;
        tick();
      end
      grant = 1'b0;
      chk("miss_done", int'(req_done), 1);
      chk("miss_nobus", bus_flags(), 0);
    end
    req_valid = 1'b0;
    tick();
    chk("idle_nodone", int'(req_done), 0);
  endtask

  task automatic snoop_exp(input logic [10:0] a, input bit s, input bit d, input bit inv,
                           input int ef, input int ebs);
    BOCI = a;
    cpu_search = s;
    cpu_datasel = d;
    invalidate_from_other_cpu = inv;
    tick();
    cpu_search = 1'b0;
    cpu_datasel = 1'b0;
    invalidate_from_other_cpu = 1'b0;
    chk("snp_found", int'(cpu_search_found), ef);
    chk("snp_bstate", int'(block_state), ebs);
  endtask

  task automatic m_access(input logic [10:0] a, input bit we, input int gd);
    logic [2:0] i;
    int t, k, wba, bs;
    bit hit, wb;
    i   = a[2:0];
    t   = int'(a[10:3]);
    hit = (m_tag[i] == t) && (m_st[i] != 0);
    if (hit && (!we || m_st[i] == 2)) k = 0;
    else if (hit)                     k = 3;
    else if (we)                      k = 2;
    else                              k = 1;
    wb  = (k != 0) && !hit && (m_st[i] == 2);
    wba = m_tag[i] * 8 + int'(i);
    bs  = (k == 3) ? m_st[i] : 0;
    access_exp(a, we, gd, k, wb, wba, bs);
    if (k != 0) begin
      m_tag[i] = t;
      m_st[i]  = (k == 1) ? 1 : 2;
    end
  endtask

  task automatic m_snoop(input logic [10:0] a, input bit s, input bit d, input bit inv);
    logic [2:0] i;
    bit match, h;
    int ef, ebs;
    i     = a[2:0];
    match = (m_tag[i] == int'(a[10:3]));
    h     = match && (m_st[i] != 0);
    ef    = (s && h) ? 1 : 0;
    ebs   = (s && h) ? m_st[i] : 0;
    snoop_exp(a, s, d, inv, ef, ebs);
    if (inv && match)                     m_st[i] = 0;
    else if (s && d && h && m_st[i] == 2) m_st[i] = 1;
  endtask

  function automatic vec_t mk_acc(input logic [10:0] a, input bit we, input int k,
                                  input bit wb, input int wba, input int bs);
    vec_t v;
    v.snp = 1'b0; v.addr = a; v.we = we; v.srch = 1'b0; v.dsel = 1'b0; v.inv = 1'b0;
    v.kind = k; v.wb = wb; v.wba = wba; v.found = 0; v.bs = bs;
    return v;
  endfunction

  function automatic vec_t mk_snp(input logic [10:0] a, input bit s, input bit d,
                                  input bit inv, input int f, input int bs);
    vec_t v;
    v.snp = 1'b1; v.addr = a; v.we = 1'b0; v.srch = s; v.dsel = d; v.inv = inv;
    v.kind = 0; v.wb = 1'b0; v.wba = 0; v.found = f; v.bs = bs;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] ra;
    logic [2:0]  rix;
    logic [7:0]  rtg;
    int          sel;

    // directed table; expectations worked out by hand from the MSI rules
    tbl.push_back(mk_snp(11'h7FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk_acc(11'h045, 0, 1, 0, 0, 0));
    tbl.push_back(mk_acc(11'h045, 0, 0, 0, 0, 0));
    tbl.push_back(mk_snp(11'h045, 1, 0, 0, 1, 1));
    tbl.push_back(mk_acc(11'h045, 1, 3, 0, 0, 1));
    tbl.push_back(mk_acc(11'h045, 1, 0, 0, 0, 0));
    tbl.push_back(mk_snp(11'h045, 1, 1, 0, 1, 2));
    tbl.push_back(mk_snp(11'h045, 1, 0, 0, 1, 1));
    tbl.push_back(mk_acc(11'h045, 1, 3, 0, 0, 1));
    tbl.push_back(mk_acc(11'h145, 0, 1, 1, 'h045, 0));
    tbl.push_back(mk_snp(11'h045, 1, 0, 0, 0, 0));
    tbl.push_back(mk_snp(11'h145, 1, 0, 0, 1, 1));
    tbl.push_back(mk_snp(11'h145, 0, 0, 1, 0, 0));
    tbl.push_back(mk_snp(11'h145, 1, 0, 0, 0, 0));
    tbl.push_back(mk_acc(11'h7FF, 1, 2, 0, 0, 0));
    tbl.push_back(mk_snp(11'h7FF, 1, 0, 0, 1, 2));
    tbl.push_back(mk_acc(11'h0FF, 0, 1, 1, 'h7FF, 0));
    tbl.push_back(mk_snp(11'h0FF, 1, 1, 0, 1, 1));
    tbl.push_back(mk_acc(11'h0FF, 1, 3, 0, 0, 1));
    tbl.push_back(mk_snp(11'h0FF, 1, 0, 1, 1, 2));
    tbl.push_back(mk_snp(11'h0FF, 1, 0, 0, 0, 0));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].snp)
        snoop_exp(tbl[k].addr, tbl[k].srch, tbl[k].dsel, tbl[k].inv, tbl[k].found, tbl[k].bs);
      else
        access_exp(tbl[k].addr, tbl[k].we, k % 3, tbl[k].kind, tbl[k].wb, tbl[k].wba, tbl[k].bs);
    end

    // pending upgrade loses its shared copy and turns into a write miss
    do_reset();
    m_access(11'h045, 1'b0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h045;
    tick();
    tick();
    chk("upg_invalidate", bus_flags(), 1);
    chk("upg_bstate_s", int'(block_state), 1);
    BOCI = 11'h045; invalidate_from_other_cpu = 1'b1;
    tick();
    invalidate_from_other_cpu = 1'b0;
    chk("upg_to_wmiss", bus_flags(), 2);
    chk("upg_bico", int'(BICO), 'h045);
    chk("upg_bstate_i", int'(block_state), 0);
    tick();
    chk("upg_wmiss_held", bus_flags(), 2);
    grant = 1'b1;
    tick();
    grant = 1'b0;
    chk("upg_done", int'(req_done), 1);
    req_valid = 1'b0;
    tick();
    snoop_exp(11'h045, 1, 0, 0, 1, 2);

    // asynchronous reset in the middle of a pending read miss
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h123;
    tick();
    tick();
    chk("rst_pre_rmiss", bus_flags(), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_clear();
    snoop_exp(11'h045, 1, 0, 0, 0, 0);
    m_access(11'h123, 1'b0, 1);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rix = 3'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 2));
      rtg = (sel == 0) ? 8'h08 : (sel == 1) ? 8'h28 : 8'hFF;
      ra  = {rtg, rix};
      if ($urandom_range(0, 2) < 2)
        m_access(ra, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      else
        m_snoop(ra, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
